axi_lite_bram_bridge: RTL

AXI_LITE_BRAM_BRIDGE -- requirements
Module: axi_lite_bram_bridge

---
 rtl/axi_lite_bram_bridge.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_bram_bridge.sv
// ----------------------------------------------------------------------------
// axi_lite_bram_bridge
//
// AXI4-Lite slave that turns single read/write transactions into accesses on
// one or more simple-dual-port BRAM banks sharing address/data/strobe lines.
// Only one transaction is in flight at a time. When both a read and a write
// request arrive together in IDLE, the class that was not served last wins.
// Accesses to a bank index >= NUM_BANKS touch no BRAM and answer SLVERR.
//
// Ports
//   ACLK, ARESET            clock, asynchronous active-high reset
//   S_AXI_AW* / W* / B*     AXI4-Lite write address, data, response channels
//   S_AXI_AR* / R*          AXI4-Lite read address and data channels
//   bram_addr/wdata/we      word address, write data, byte enables (shared)
//   bram_en                 one-hot bank enable
//   bram_rdata              bank k read data at [k*DATA_W +: DATA_W]
//   err_cnt                 saturating count of SLVERR responses accepted
// ----------------------------------------------------------------------------
module axi_lite_bram_bridge #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int NUM_BANKS = 1,
  parameter int RD_LAT    = 1,
  localparam int BW     = DATA_W / 8,
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int OFF_W  = $clog2(BW),
  localparam int AXI_AW = ADDR_W + BANK_W + OFF_W
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  // write address channel
  input  logic [AXI_AW-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  // write data channel
  input  logic [DATA_W-1:0]             S_AXI_WDATA,
  input  logic [BW-1:0]                 S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  // write response channel
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  // read address channel
  input  logic [AXI_AW-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  // read data channel
  output logic [DATA_W-1:0]             S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  // BRAM side
  output logic [ADDR_W-1:0]             bram_addr,
  output logic [DATA_W-1:0]             bram_wdata,
  output logic [BW-1:0]                 bram_we,
  output logic [NUM_BANKS-1:0]          bram_en,
  input  logic [NUM_BANKS*DATA_W-1:0]   bram_rdata,
  output logic [15:0]                   err_cnt
);

  typedef enum logic [2:0] {
    IDLE, W_DATA, W_BRAM, W_RESP, R_BRAM, R_WAIT, R_RESP
  } state_t;

  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [BANK_W:0]   BANK_LIMIT  = (BANK_W + 1)'(NUM_BANKS);
  localparam logic              LAT_LAST    = 1'(RD_LAT - 1);

  state_t              state;
  logic [AXI_AW-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BW-1:0]       wstrb_q;
  logic                last_read;   // 1 = read was the last class granted
  logic                lat_cnt;

  logic [BANK_W-1:0]   bank;
  logic                in_range;
  logic                grant_wr;
  logic                grant_rd;
  logic                idle_free;
  logic [DATA_W-1:0]   bank_rdata;

  assign bank      = addr_q[OFF_W + ADDR_W +: BANK_W];
  assign in_range  = ({1'b0, bank} < BANK_LIMIT);
  assign bram_addr = addr_q[OFF_W +: ADDR_W];
  assign bram_wdata = wdata_q;

  // Round-robin only matters on a tie; a lone request always wins.
  assign grant_wr  = S_AXI_AWVALID && (!S_AXI_ARVALID || last_read);
  assign grant_rd  = S_AXI_ARVALID && (!S_AXI_AWVALID || !last_read);

  // Address READYs are combinational, so they are gated with the reset
  // directly to stay low while ARESET is held.
  assign idle_free     = (state == IDLE) && !ARESET;
  assign S_AXI_AWREADY = idle_free && grant_wr;
  assign S_AXI_ARREADY = idle_free && grant_rd;
  assign S_AXI_WREADY  = (state == W_DATA);
  assign S_AXI_BVALID  = (state == W_RESP);
  assign S_AXI_RVALID  = (state == R_RESP);

  assign bram_we = (state == W_BRAM && in_range) ? wstrb_q : '0;

  // An out-of-range bank index matches no k, so its enable stays low and
  // its read slice is zero without any extra qualification.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bram_en    = '0;
    bank_rdata = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank == BANK_W'(k)) begin
        bram_en[k] = (state == W_BRAM) || (state == R_BRAM);
        bank_rdata = bram_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      last_read   <= 1'b1;
      lat_cnt     <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_BRESP <= RESP_OKAY;
      S_AXI_RRESP <= RESP_OKAY;
      err_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (S_AXI_AWREADY) begin
            addr_q    <= S_AXI_AWADDR;
            last_read <= 1'b0;
            state     <= W_DATA;
          end else if (S_AXI_ARREADY) begin
            addr_q    <= S_AXI_ARADDR;
            last_read <= 1'b1;
            state     <= R_BRAM;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
            state   <= W_BRAM;
          end
        end
        W_BRAM: begin
          S_AXI_BRESP <= in_range ? RESP_OKAY : RESP_SLVERR;
          state       <= W_RESP;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            state <= IDLE;
            if (S_AXI_BRESP == RESP_SLVERR && err_cnt != 16'hFFFF)
              err_cnt <= err_cnt + 16'd1;
          end
        end
        R_BRAM: begin
          lat_cnt <= 1'b0;
          state   <= R_WAIT;
        end
        R_WAIT: begin
          // Data requested in R_BRAM is valid on the last R_WAIT cycle.
          if (lat_cnt == LAT_LAST) begin
            S_AXI_RDATA <= bank_rdata;
            S_AXI_RRESP <= in_range ? RESP_OKAY : RESP_SLVERR;
            state       <= R_RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            state <= IDLE;
            if (S_AXI_RRESP == RESP_SLVERR && err_cnt != 16'hFFFF)
              err_cnt <= err_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Protection bits and the byte offset carry no meaning for word BRAM.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, addr_q[OFF_W-1:0]};

endmodule
